// File: rtl/ysyx_23060124_mem_arbiter.sv
// Two-requester (IFU fetch, LSU load/store) arbiter for one memory port.
// It allows one outstanding transaction and has a WAIT watchdog.
// Define YSYX_23060124_ARB_RR_EN to select round-robin tie-breaking; fixed LSU priority otherwise.
module ysyx_23060124_mem_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              ifu_valid,
  output logic              ifu_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  output logic              ifu_rvalid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              ifu_err,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_rvalid,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              lsu_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  localparam logic OwnIfu = 1'b0;
  localparam logic OwnLsu = 1'b1;
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic              owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [7:0]        cnt_q;
  logic              grant_lsu;
  logic              grant;
  logic              lsu_store;

`ifdef YSYX_23060124_ARB_RR_EN
  logic last_owner_q;

  // On a tie the requester not served last wins; reset to IFU so LSU takes the first tie.
  assign grant_lsu = lsu_valid && (!ifu_valid || (last_owner_q == OwnIfu));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_owner_q <= OwnIfu;
    end else if (grant) begin
      last_owner_q <= grant_lsu;
    end
  end
`else
  assign grant_lsu = lsu_valid;
`endif

  assign lsu_ready = (state_q == StIdle) && grant_lsu;
  assign ifu_ready = (state_q == StIdle) && ifu_valid && !grant_lsu;
  assign grant     = lsu_ready || ifu_ready;
  assign lsu_store = grant_lsu && lsu_wen;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      owner_q <= OwnIfu;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= 4'b0000;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            owner_q <= grant_lsu;
            addr_q  <= grant_lsu ? lsu_addr : ifu_addr;
            wen_q   <= lsu_store;
            wdata_q <= lsu_store ? lsu_wdata : '0;
            wmask_q <= lsu_store ? lsu_wmask : 4'b0000;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (mem_ready) begin
            cnt_q <= 8'd0;
            // Response in the same cycle as the accept skips WAIT entirely.
            if (mem_rvalid) begin
              rdata_q <= wen_q ? '0 : mem_rdata;
              err_q   <= mem_err;
              state_q <= StResp;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (mem_rvalid) begin
            rdata_q <= wen_q ? '0 : mem_rdata;
            err_q   <= mem_err;
            state_q <= StResp;
          end else if (cnt_q == TimeoutLast) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mem_valid = (state_q == StReq);
  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

  assign ifu_rvalid = (state_q == StResp) && (owner_q == OwnIfu);
  assign lsu_rvalid = (state_q == StResp) && (owner_q == OwnLsu);
  assign ifu_rdata  = ifu_rvalid ? rdata_q : '0;
  assign lsu_rdata  = lsu_rvalid ? rdata_q : '0;
  assign ifu_err    = ifu_rvalid && err_q;
  assign lsu_err    = lsu_rvalid && err_q;

endmodule

// File: tb/tb_ysyx_23060124_mem_arbiter.sv
// Directed self-checking bench for ysyx_23060124_mem_arbiter.
module tb_ysyx_23060124_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifu_valid, ifu_ready, ifu_rvalid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_valid, lsu_ready, lsu_wen, lsu_rvalid, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_valid, mem_ready, mem_wen, mem_rvalid, mem_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int xfer_base;
  bit first_lsu;

  ysyx_23060124_mem_arbiter dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .ifu_valid  (ifu_valid),
    .ifu_ready  (ifu_ready),
    .ifu_addr   (ifu_addr),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rdata  (ifu_rdata),
    .ifu_err    (ifu_err),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_addr   (lsu_addr),
    .lsu_wen    (lsu_wen),
    .lsu_wdata  (lsu_wdata),
    .lsu_wmask  (lsu_wmask),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .lsu_err    (lsu_err),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && mem_valid && mem_ready) xfers++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef YSYX_23060124_ARB_RR_EN
    first_lsu = 1'b0;
`else
    first_lsu = 1'b1;
`endif
    rst_n = 1'b0;
    ifu_valid = 0; ifu_addr = 0;
    lsu_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0;
    tick();
    tick();
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_ifu_rvalid", ifu_rvalid, 0);
    check("rst_lsu_rvalid", lsu_rvalid, 0);
    check("rst_ifu_ready", ifu_ready, 0);
    rst_n = 1'b1;
    tick();

    // 1: IFU fetch, immediate memory.
    ifu_valid = 1; ifu_addr = 32'h8000_0000;
    #1 check("t1_ifu_ready", ifu_ready, 1);
    check("t1_lsu_ready", lsu_ready, 0);
    tick();
    ifu_valid = 0;
    check("t1_mem_valid", mem_valid, 1);
    check("t1_mem_addr", mem_addr, 32'h8000_0000);
    check("t1_mem_wen", mem_wen, 0);
    check("t1_mem_wmask", mem_wmask, 0);
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0413;
    tick();
    mem_ready = 0; mem_rvalid = 0;
    check("t1_ifu_rvalid", ifu_rvalid, 1);
    check("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    check("t1_ifu_err", ifu_err, 0);
    check("t1_lsu_rvalid", lsu_rvalid, 0);
    tick();
    check("t1_ifu_rvalid_off", ifu_rvalid, 0);
    check("t1_mem_valid_off", mem_valid, 0);

    // 2: LSU store word.
    lsu_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b1111;
    #1 check("t2_lsu_ready", lsu_ready, 1);
    tick();
    lsu_valid = 0;
    check("t2_mem_wen", mem_wen, 1);
    check("t2_mem_wmask", mem_wmask, 4'b1111);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t2_mem_addr", mem_addr, 32'h8000_1000);
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ready = 0; mem_rvalid = 0;
    check("t2_lsu_rvalid", lsu_rvalid, 1);
    check("t2_lsu_rdata", lsu_rdata, 0);
    check("t2_lsu_err", lsu_err, 0);
    check("t2_ifu_rvalid", ifu_rvalid, 0);
    tick();

    // 3: simultaneous requests; LSU load with a nonzero mask that must not reach memory.
    ifu_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000; lsu_wmask = 4'b1111;
    #1 check("t3_lsu_ready", lsu_ready, {31'd0, first_lsu});
    check("t3_ifu_ready", ifu_ready, {31'd0, !first_lsu});
    tick();
    if (first_lsu) lsu_valid = 0; else ifu_valid = 0;
    check("t3_first_addr", mem_addr, first_lsu ? 32'h8000_3000 : 32'h8000_0100);
    check("t3_first_wmask", mem_wmask, 0);
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h1111_1111;
    tick();
    mem_ready = 0; mem_rvalid = 0;
    check("t3_first_lsu_rvalid", lsu_rvalid, {31'd0, first_lsu});
    check("t3_first_ifu_rvalid", ifu_rvalid, {31'd0, !first_lsu});
    check("t3_resp_no_ready", {30'd0, ifu_ready, lsu_ready}, 0);
    tick();
    check("t3_second_ifu_ready", ifu_ready, {31'd0, first_lsu});
    check("t3_second_lsu_ready", lsu_ready, {31'd0, !first_lsu});
    tick();
    ifu_valid = 0; lsu_valid = 0;
    check("t3_second_addr", mem_addr, first_lsu ? 32'h8000_0100 : 32'h8000_3000);
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h2222_2222;
    tick();
    mem_ready = 0; mem_rvalid = 0;
    check("t3_second_rdata", first_lsu ? ifu_rdata : lsu_rdata, 32'h2222_2222);
    check("t3_second_rvalid", first_lsu ? ifu_rvalid : lsu_rvalid, 1);
    tick();

    // 4: watchdog, 255 WAIT cycles.
    ifu_valid = 1; ifu_addr = 32'h8000_0010;
    tick();
    ifu_valid = 0;
    mem_ready = 1;
    tick();
    mem_ready = 0;
    repeat (254) tick();
    check("t4_before_timeout", ifu_rvalid, 0);
    tick();
    check("t4_timeout_rvalid", ifu_rvalid, 1);
    check("t4_timeout_err", ifu_err, 1);
    check("t4_timeout_rdata", ifu_rdata, 0);
    tick();
    check("t4_idle_mem_valid", mem_valid, 0);
    mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    mem_rvalid = 0;
    check("t4_late_ifu_rvalid", ifu_rvalid, 0);
    check("t4_late_lsu_rvalid", lsu_rvalid, 0);
    check("t4_late_mem_valid", mem_valid, 0);

    // 5: asynchronous reset during WAIT.
    ifu_valid = 1; ifu_addr = 32'h8000_0020;
    tick();
    ifu_valid = 0;
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tick();
    #2 rst_n = 1'b0;
    #1 check("t5_rst_mem_valid", mem_valid, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_rvalids", {30'd0, ifu_rvalid, lsu_rvalid}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    ifu_valid = 1; ifu_addr = 32'h8000_0024;
    #1 check("t5_post_ready", ifu_ready, 1);
    tick();
    ifu_valid = 0;
    mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h0051_0513;
    tick();
    mem_ready = 0; mem_rvalid = 0;
    check("t5_post_rvalid", ifu_rvalid, 1);
    check("t5_post_rdata", ifu_rdata, 32'h0051_0513);
    tick();

    // 6: downstream backpressure on a halfword store; inputs change after grant.
    lsu_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_2006;
    lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'b1100;
    tick();
    lsu_valid = 0; lsu_addr = 32'h0BAD_0BAD; lsu_wdata = 32'h5555_5555; lsu_wmask = 4'b0001;
    xfer_base = xfers;
    for (int i = 0; i < 5; i++) begin
      check("t6_hold_valid", mem_valid, 1);
      check("t6_hold_addr", mem_addr, 32'h8000_2006);
      check("t6_hold_wdata", mem_wdata, 32'hCAFE_F00D);
      tick();
    end
    check("t6_wmask", mem_wmask, 4'b1100);
    mem_ready = 1;
    tick();
    mem_ready = 0;
    check("t6_wait_mem_valid", mem_valid, 0);
    mem_rvalid = 1; mem_err = 1; mem_rdata = 32'h7777_7777;
    tick();
    mem_rvalid = 0; mem_err = 0;
    check("t6_lsu_rvalid", lsu_rvalid, 1);
    check("t6_lsu_err", lsu_err, 1);
    check("t6_lsu_rdata", lsu_rdata, 0);
    tick();
    check("t6_single_xfer", xfers - xfer_base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
